button_hold_classifier: RTL and testbench

//   Multi-channel keypad/button front end for the lock. Each channel synchronises and

---
 rtl/fechadura_pkg.sv | 5 +
 rtl/hold_channel.sv | 106 ++++++++++
 rtl/button_hold_classifier.sv | 59 +++++
 tb/tb_button_hold_classifier.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fechadura_pkg.sv
// fechadura_pkg: shared types and constants for the lock button front end
package fechadura_pkg;
  typedef enum logic [2:0] {IDLE, DEB, PRESS, REL_S, LONG, REL_L} hold_state_t;
  localparam int MS_PER_S = 1000;
endpackage

// File: rtl/hold_channel.sv
// hold_channel: synchronise, debounce and classify one button as short or long press
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : 0 forces the channel to IDLE with counters and outputs cleared
//   tick         : 1 ms strobe from the shared prescaler
//   btn_in       : raw button level, asynchronous to clk
//   short_press  : 1-cycle pulse when a debounced press is released before HOLD_MS
//   long_press   : 1-cycle pulse when a press reaches HOLD_MS
//   hold_active  : level from long_press until the release is debounced
module hold_channel
  import fechadura_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic tick,
  input  logic btn_in,
  output logic short_press,
  output logic long_press,
  output logic hold_active
);
  localparam int MW = $clog2(HOLD_MS + 1);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [MW-1:0] MS_MAX  = MW'(HOLD_MS);
  localparam logic [MW-1:0] MS_LAST = MW'(HOLD_MS - 1);
  localparam logic [DW-1:0] D_MAX   = DW'(DEBOUNCE_MS);
  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_MS - 1);
  logic [1:0]    sync_q;
  logic          s;
  hold_state_t   state_q, state_d;
  logic [MW-1:0] ms_q, ms_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          hold_q, hold_d;
  logic          deb_done, hold_done, ms_run, entering;
  assign s = sync_q[1];
  // Transitions fire on the tick that would bring the counter to its target,
  // so the new state and the counter value line up on the same edge.
  assign deb_done  = tick && dcnt_q == D_LAST;
  assign hold_done = tick && ms_q == MS_LAST;
  assign ms_run    = state_q == DEB || state_q == PRESS || state_q == LONG;
  assign entering  = state_d != state_q;
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE:    if (s) state_d = DEB;
      DEB:     if (!s) state_d = IDLE;
               else if (deb_done) state_d = PRESS;
      PRESS:   if (!s) state_d = REL_S;
               else if (hold_done) begin
                 state_d = LONG;
                 long_d  = 1'b1;
               end
      REL_S:   if (s) state_d = PRESS;
               else if (deb_done) begin
                 state_d = IDLE;
                 short_d = 1'b1;
               end
      LONG:    if (!s) state_d = REL_L;
      REL_L:   if (s) state_d = LONG;
               else if (deb_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      short_d = 1'b0;
      long_d  = 1'b0;
    end
  end
  // Debounce counter restarts on every state change; it saturates so idle
  // states never wrap it.
  assign dcnt_d = (!enable || entering) ? '0 :
                  (tick && dcnt_q != D_MAX) ? dcnt_q + 1'b1 : dcnt_q;
  // Press duration is kept across release glitches (frozen in REL_S/REL_L)
  // and only restarts when a brand-new press begins.
  assign ms_d = (!enable || (state_q == IDLE && state_d == DEB)) ? '0 :
                (ms_run && tick && ms_q != MS_MAX) ? ms_q + 1'b1 : ms_q;
  assign hold_d = state_d == LONG || state_d == REL_L;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ms_q    <= '0;
      dcnt_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_in};
      state_q <= state_d;
      ms_q    <= ms_d;
      dcnt_q  <= dcnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      hold_q  <= hold_d;
    end
  end
  assign short_press = short_q;
  assign long_press  = long_q;
  assign hold_active = hold_q;
endmodule

// File: rtl/button_hold_classifier.sv
// button_hold_classifier: multi-channel debounced short/long press classifier for the lock
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : 0 forces every channel to IDLE, outputs held 0
//   btn_in       : N_CH raw button levels, 1 = pressed
//   short_press  : per-channel 1-cycle pulse for a press released before HOLD_MS
//   long_press   : per-channel 1-cycle pulse when a press reaches HOLD_MS
//   hold_active  : per-channel level from long_press until release is debounced
module button_hold_classifier
  import fechadura_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CLK_HZ      = 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 5000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] short_press,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] hold_active
);
  localparam int DIV = CLK_HZ / MS_PER_S;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  if (CLK_HZ % MS_PER_S != 0) begin : g_bad_clk
    $error("CLK_HZ must be a multiple of 1000");
  end
  if (DEBOUNCE_MS < 1) begin : g_bad_deb
    $error("DEBOUNCE_MS must be at least 1");
  end
  if (HOLD_MS <= DEBOUNCE_MS) begin : g_bad_hold
    $error("HOLD_MS must exceed DEBOUNCE_MS");
  end
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  // With DIV == 1 the prescaler sits at 0 and tick stays high every cycle.
  assign tick  = pre_q == PW'(DIV - 1);
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else pre_q <= pre_d;
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    hold_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .HOLD_MS    (HOLD_MS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .tick       (tick),
      .btn_in     (btn_in[i]),
      .short_press(short_press[i]),
      .long_press (long_press[i]),
      .hold_active(hold_active[i])
    );
  end
endmodule

// File: tb/tb_button_hold_classifier.sv
// tb_button_hold_classifier: scoreboard bench for the press classifier
module tb_button_hold_classifier;
  localparam int N = 2;
  typedef struct {
    int           cyc;
    logic [N-1:0] sp;
    logic [N-1:0] lp;
  } ev_t;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] short_press, long_press, hold_active;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           t0, f, e, m;
  ev_t          exp_q[$];
  ev_t          got_e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  button_hold_classifier #(
    .N_CH       (N),
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(20),
    .HOLD_MS    (5000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .btn_in     (btn_in),
    .short_press(short_press),
    .long_press (long_press),
    .hold_active(hold_active)
  );
  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  task automatic expect_ev(input int at, input int ch, input bit is_long);
    int  i = 0;
    ev_t x;
    while (i < exp_q.size() && exp_q[i].cyc < at) i++;
    if (i < exp_q.size() && exp_q[i].cyc == at) begin
      x = exp_q[i];
      if (is_long) x.lp[ch] = 1'b1;
      else x.sp[ch] = 1'b1;
      exp_q[i] = x;
    end else begin
      x.cyc = at;
      x.sp  = '0;
      x.lp  = '0;
      if (is_long) x.lp[ch] = 1'b1;
      else x.sp[ch] = 1'b1;
      exp_q.insert(i, x);
    end
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (!reset && (short_press != '0 || long_press != '0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'({short_press, long_press}), 0);
      end else begin
        got_e = exp_q.pop_front();
        check("pulse_cycle", cyc, got_e.cyc);
        check("short_press", int'(short_press), int'(got_e.sp));
        check("long_press", int'(long_press), int'(got_e.lp));
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_short", int'(short_press), 0);
    check("rst_long", int'(long_press), 0);
    check("rst_hold", int'(hold_active), 0);
    reset = 1'b0;
    wait_cyc(cyc + 5);
    // glitch shorter than debounce: nothing
    btn_in[0] = 1'b1;
    wait_cyc(cyc + 10);
    btn_in[0] = 1'b0;
    wait_cyc(cyc + 40);
    check("t1_hold", int'(hold_active), 0);
    // short press
    m = cyc;
    btn_in[0] = 1'b1;
    wait_cyc(m + 300);
    btn_in[0] = 1'b0;
    expect_ev(cyc + 1 + 22, 0, 1'b0);
    wait_cyc(cyc + 40);
    check("t2_hold", int'(hold_active), 0);
    // long press on ch1, release glitch, concurrent short on ch0
    btn_in[1] = 1'b1;
    t0 = cyc + 1;
    expect_ev(t0 + 5002, 1, 1'b1);
    wait_cyc(t0 + 5001);
    check("t3_hold_before", int'(hold_active[1]), 0);
    wait_cyc(t0 + 5002);
    check("t3_hold_rise", int'(hold_active[1]), 1);
    wait_cyc(t0 + 5300);
    btn_in[0] = 1'b1;
    wait_cyc(t0 + 5500);
    btn_in[1] = 1'b0;
    wait_cyc(t0 + 5505);
    btn_in[1] = 1'b1;
    wait_cyc(t0 + 5510);
    check("t4_hold_glitch", int'(hold_active[1]), 1);
    wait_cyc(t0 + 5600);
    btn_in[0] = 1'b0;
    expect_ev(t0 + 5601 + 22, 0, 1'b0);
    wait_cyc(t0 + 6000);
    btn_in[1] = 1'b0;
    f = t0 + 6001;
    wait_cyc(f + 21);
    check("t3_hold_late", int'(hold_active[1]), 1);
    wait_cyc(f + 22);
    check("t3_hold_fall", int'(hold_active[1]), 0);
    // simultaneous long on both channels, then reset mid-hold
    wait_cyc(cyc + 30);
    btn_in = 2'b11;
    t0 = cyc + 1;
    expect_ev(t0 + 5002, 0, 1'b1);
    expect_ev(t0 + 5002, 1, 1'b1);
    wait_cyc(t0 + 5100);
    check("t5_hold_both", int'(hold_active), 3);
    reset = 1'b1;
    #1;
    check("t5_rst_hold", int'(hold_active), 0);
    check("t5_rst_pulses", int'({short_press, long_press}), 0);
    btn_in[1] = 1'b0;
    @(negedge clk);
    wait_cyc(cyc + 3);
    reset = 1'b0;
    t0 = cyc + 1;
    expect_ev(t0 + 5002, 0, 1'b1);
    wait_cyc(t0 + 5001);
    check("t5_hold_before", int'(hold_active[0]), 0);
    wait_cyc(t0 + 5002);
    check("t5_hold_rise", int'(hold_active[0]), 1);
    wait_cyc(t0 + 5050);
    btn_in[0] = 1'b0;
    f = cyc + 1;
    wait_cyc(f + 22);
    check("t5_hold_fall", int'(hold_active[0]), 0);
    // enable low mid-press restarts the debounce
    wait_cyc(cyc + 10);
    btn_in[0] = 1'b1;
    t0 = cyc + 1;
    wait_cyc(t0 + 3000);
    e = cyc;
    enable = 1'b0;
    wait_cyc(e + 5);
    check("t6_hold_disabled", int'(hold_active), 0);
    wait_cyc(e + 10);
    enable = 1'b1;
    expect_ev(e + 5011, 0, 1'b1);
    wait_cyc(e + 5010);
    check("t6_hold_before", int'(hold_active[0]), 0);
    wait_cyc(e + 5011);
    check("t6_hold_rise", int'(hold_active[0]), 1);
    btn_in[0] = 1'b0;
    wait_cyc(cyc + 30);
    check("t6_hold_fall", int'(hold_active), 0);
    wait_cyc(cyc + 5);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
